// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and CRC-8 defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CRC_LOAD,
        CRC_WAIT
    } state_e;

    localparam logic [7:0] CRC_POLY_DEF = 8'h07;
    localparam logic [7:0] CRC_INIT_DEF = 8'h00;

endpackage

// File: rtl/crc8_step.sv
// One byte of CRC-8 (MSB-first, no reflection), folded into a single combinational step.
module crc8_step
    import uart_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY_DEF
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int unsigned b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding byte frames from N_REQ requesters into one UART transmitter,
// optionally appending a CRC-8 byte, with a per-byte completion timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter logic [7:0]  CRC_POLY = CRC_POLY_DEF,
    parameter logic [7:0]  CRC_INIT = CRC_INIT_DEF,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic               clk_master,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [N_REQ-1:0]   grant_o,
    input  logic               crc_en_i,
    output logic [7:0]         utx_data_o,
    output logic               utx_we_o,
    output logic               utx_en_o,
    input  logic               utx_done_i,
    output logic               busy_o,
    output logic               err_o
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e           state_q;
    logic [IW-1:0]    gidx_q;
    logic [IW-1:0]    ptr_q;
    logic [7:0]       crc_q;
    logic             last_q;
    logic             crc_en_q;
    logic [TW-1:0]    tmo_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] ack_q;
    logic [7:0]       data_q;
    logic             we_q;
    logic             busy_q;
    logic             err_q;

    logic             win_found_d;
    logic [IW-1:0]    win_idx_d;
    logic [N_REQ-1:0] win_onehot_d;
    logic [IW-1:0]    ptr_d;
    logic [7:0]       cur_byte_d;
    logic [7:0]       crc_d;
    logic             tmo_hit_d;

    // Scan starts at the requester after the previous winner.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        win_found_d  = 1'b0;
        win_idx_d    = '0;
        win_onehot_d = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!win_found_d && req_i[idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = IW'(idx);
            end
        end
        win_onehot_d[win_idx_d] = 1'b1;
        ptr_d = IW'((int'(win_idx_d) + 1) % N_REQ);
    end

    assign cur_byte_d = req_data_i[8*gidx_q +: 8];
    assign tmo_hit_d  = (tmo_q == TW'(TIMEOUT - 1));

    crc8_step #(.POLY(CRC_POLY)) u_crc (
        .crc_in  (crc_q),
        .data_in (cur_byte_d),
        .crc_out (crc_d)
    );

    always_ff @(posedge clk_master or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            gidx_q   <= '0;
            ptr_q    <= '0;
            crc_q    <= CRC_INIT;
            last_q   <= 1'b0;
            crc_en_q <= 1'b0;
            tmo_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        grant_q  <= win_onehot_d;
                        gidx_q   <= win_idx_d;
                        ptr_q    <= ptr_d;
                        busy_q   <= 1'b1;
                        crc_q    <= CRC_INIT;
                        crc_en_q <= crc_en_i;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (req_i[gidx_q]) begin
                        data_q        <= cur_byte_d;
                        we_q          <= 1'b1;
                        ack_q[gidx_q] <= 1'b1;
                        crc_q         <= crc_d;
                        last_q        <= req_last_i[gidx_q];
                        tmo_q         <= '0;
                        state_q       <= WAIT;
                    end else begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (utx_done_i) begin
                        if (!last_q) begin
                            state_q <= LOAD;
                        end else if (crc_en_q) begin
                            state_q <= CRC_LOAD;
                        end else begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (tmo_hit_d) begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                CRC_LOAD: begin
                    data_q  <= crc_q;
                    we_q    <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= CRC_WAIT;
                end
                CRC_WAIT: begin
                    if (utx_done_i || tmo_hit_d) begin
                        err_q   <= !utx_done_i;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ack_o  = ack_q;
    assign grant_o    = grant_q;
    assign utx_data_o = data_q;
    assign utx_we_o   = we_q;
    assign utx_en_o   = busy_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester/transmitter models plus byte and grant scoreboards.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] rdata = '0;
    logic [3:0]  rlast = '0;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        crc_en = 1'b0;
    logic [7:0]  tx_data;
    logic        we;
    logic        en;
    logic        done = 1'b0;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ    (4),
        .CRC_POLY (8'h07),
        .CRC_INIT (8'h00),
        .TIMEOUT  (16)
    ) dut (
        .clk_master (clk),
        .rst_i      (rst_n),
        .req_i      (req),
        .req_data_i (rdata),
        .req_last_i (rlast),
        .req_ack_o  (ack),
        .grant_o    (grant),
        .crc_en_i   (crc_en),
        .utx_data_o (tx_data),
        .utx_we_o   (we),
        .utx_en_o   (en),
        .utx_done_i (done),
        .busy_o     (busy),
        .err_o      (err)
    );

    logic [7:0] fdata [4][16];
    bit         flast [4][16];
    int         fcnt [4] = '{0, 0, 0, 0};
    int         fidx [4] = '{0, 0, 0, 0};
    int         ack_cnt [4] = '{0, 0, 0, 0};

    logic [7:0] exp_bytes [$];
    logic [3:0] exp_grants [$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   bytes_seen = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   we_cyc = 0;
    int   err_cyc = 0;
    bit   tx_ok = 1'b1;
    logic [3:0] prev_grant = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input bit l);
        fdata[r][fcnt[r]] = d;
        flast[r][fcnt[r]] = l;
        fcnt[r]++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        tick();
        tick();
        while ((busy || req != 4'b0) && k < maxc) begin
            tick();
            k++;
        end
        chk("idle_wait", 32'(busy || req != 4'b0), 32'd0);
    endtask

    // Requester model: advances on each ack; sole driver of req/data/last.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) fidx[i]++;
                if (fidx[i] < fcnt[i]) begin
                    req[i]          = 1'b1;
                    rdata[8*i +: 8] = fdata[i][fidx[i]];
                    rlast[i]        = flast[i][fidx[i]];
                end else begin
                    req[i]          = 1'b0;
                    rdata[8*i +: 8] = 8'h00;
                    rlast[i]        = 1'b0;
                end
            end
        end
    end

    // Transmitter model: completes each byte three cycles after its write strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (we && tx_ok && rst_n) begin
                repeat (3) @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (done) done_cnt++;
        end
    end

    // Output monitor: pops scoreboards on each write strobe and each new grant.
    initial begin
        logic [7:0] eb;
        logic [3:0] eg;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (we) begin
                    bytes_seen++;
                    we_cyc = cyc;
                    if (exp_bytes.size() == 0) begin
                        chk("byte_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        eb = exp_bytes.pop_front();
                        chk("tx_byte", 32'(tx_data), 32'(eb));
                    end
                end
                if (grant != 4'b0 && prev_grant == 4'b0) begin
                    if (exp_grants.size() == 0) begin
                        chk("grant_unexpected", 32'(grant), 32'hFFFF_FFFF);
                    end else begin
                        eg = exp_grants.pop_front();
                        chk("grant_order", 32'(grant), 32'(eg));
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) ack_cnt[i]++;
                end
                if (err) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        int a0, d0, b0, e0, k;

        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Round-robin over requesters 0, 1 and 3 with one-byte frames.
        crc_en = 1'b0;
        exp_grants.push_back(4'b0001); exp_grants.push_back(4'b0010);
        exp_grants.push_back(4'b1000); exp_grants.push_back(4'b0001);
        exp_grants.push_back(4'b0010);
        exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'hB1);
        exp_bytes.push_back(8'hD3); exp_bytes.push_back(8'hA2);
        exp_bytes.push_back(8'hB2);
        add_byte(0, 8'hA0, 1'b1); add_byte(0, 8'hA2, 1'b1);
        add_byte(1, 8'hB1, 1'b1); add_byte(1, 8'hB2, 1'b1);
        add_byte(3, 8'hD3, 1'b1);
        wait_idle(300);
        chk("rr_grants_left", 32'(exp_grants.size()), 32'd0);
        chk("rr_bytes_left", 32'(exp_bytes.size()), 32'd0);
        chk("rr_ack3", 32'(ack_cnt[3]), 32'd1);

        // Two-byte frame with CRC from requester 0.
        a0 = ack_cnt[0];
        d0 = done_cnt;
        crc_en = 1'b1;
        exp_grants.push_back(4'b0001);
        exp_bytes.push_back(8'hDA); exp_bytes.push_back(8'h2D); exp_bytes.push_back(8'hFB);
        add_byte(0, 8'hDA, 1'b0); add_byte(0, 8'h2D, 1'b1);
        wait_idle(200);
        chk("crc2_acks", 32'(ack_cnt[0] - a0), 32'd2);
        chk("crc2_dones", 32'(done_cnt - d0), 32'd3);
        chk("crc2_busy", 32'(busy), 32'd0);
        chk("crc2_en", 32'(en), 32'd0);
        chk("crc2_bytes_left", 32'(exp_bytes.size()), 32'd0);

        // Single byte from requester 1, with and without CRC.
        exp_grants.push_back(4'b0010);
        exp_bytes.push_back(8'hDA); exp_bytes.push_back(8'h08);
        add_byte(1, 8'hDA, 1'b1);
        wait_idle(200);
        chk("crc1_bytes_left", 32'(exp_bytes.size()), 32'd0);
        crc_en = 1'b0;
        b0 = bytes_seen;
        exp_grants.push_back(4'b0010);
        exp_bytes.push_back(8'hDA);
        add_byte(1, 8'hDA, 1'b1);
        wait_idle(200);
        chk("nocrc_count", 32'(bytes_seen - b0), 32'd1);
        chk("nocrc_bytes_left", 32'(exp_bytes.size()), 32'd0);

        // Transmitter never completes: timeout abort.
        tx_ok = 1'b0;
        e0 = err_cnt;
        exp_grants.push_back(4'b0100);
        exp_bytes.push_back(8'h55);
        add_byte(2, 8'h55, 1'b1);
        wait_idle(100);
        chk("tmo_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("tmo_latency", 32'(err_cyc - we_cyc), 32'd16);
        chk("tmo_grant", 32'(grant), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        tx_ok = 1'b1;
        tick();

        // Reset in the middle of a three-byte frame.
        e0 = err_cnt;
        crc_en = 1'b1;
        b0 = bytes_seen;
        exp_grants.push_back(4'b0001);
        exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h22);
        add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h22, 1'b0); add_byte(0, 8'h33, 1'b1);
        k = 0;
        while (bytes_seen < b0 + 2 && k < 100) begin
            tick();
            k++;
        end
        chk("mid_reach_wait", 32'(bytes_seen - b0), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_data", 32'(tx_data), 32'd0);
        fcnt[0] = fidx[0];
        repeat (5) tick();
        chk("arst_no_err", 32'(err_cnt - e0), 32'd0);
        chk("arst_bytes_left", 32'(exp_bytes.size()), 32'd0);
        rst_n = 1'b1;
        tick();
        crc_en = 1'b0;
        exp_grants.push_back(4'b0100);
        exp_bytes.push_back(8'h77);
        add_byte(2, 8'h77, 1'b1);
        tick();
        tick();
        chk("post_rst_grant", 32'(grant), 32'h4);
        wait_idle(200);
        chk("final_grants_left", 32'(exp_grants.size()), 32'd0);
        chk("final_bytes_left", 32'(exp_bytes.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters.
REQ-002 SHALL have parameter CRC_POLY, default 8'h07, CRC-8 polynomial (MSB-first, no reflection, no final XOR).
REQ-003 SHALL have parameter CRC_INIT, default 8'h00, CRC register value at frame start.
REQ-004 SHALL have parameter TIMEOUT, default 4096, clk_master cycles to wait for utx_done_i before aborting.
REQ-005 SHALL have port clk_master  in  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst_i  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_i  in  N_REQ  requester i has a frame pending; held high until its last byte is acked.
REQ-008 SHALL have port req_data_i  in  8*N_REQ  current byte of requester i, at bits [8i+7:8i].
REQ-009 SHALL have port req_last_i  in  N_REQ  current byte of requester i is the final byte of its frame.
REQ-010 SHALL have port req_ack_o  out  N_REQ  one-cycle pulse: the current byte was taken; requester advances.
REQ-011 SHALL have port grant_o  out  N_REQ  one-hot current owner, all-zero when idle.
REQ-012 SHALL have port crc_en_i  in  1  append CRC byte to the frame; sampled at grant.
REQ-013 SHALL have port utx_data_o  out  8  byte to the UART transmitter data input.
REQ-014 SHALL have port utx_we_o  out  1  one-cycle write strobe to the UART transmitter.
REQ-015 SHALL have port utx_en_o  out  1  transmitter enable; high exactly while busy_o is high.
REQ-016 SHALL have port utx_done_i  in  1  one-cycle pulse, synchronous to clk_master: the transmitter finished one byte.
REQ-017 SHALL have port busy_o  out  1  a frame is in progress.
REQ-018 SHALL have port err_o  out  1  one-cycle pulse on abort (timeout or request drop).

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WAIT, CRC_LOAD, CRC_WAIT.
REQ-020 In IDLE with any req_i high, SHALL pick the winner round-robin, scanning from (last winner + 1) mod N_REQ; after reset the scan starts at 0.
REQ-021 SHALL register grant_o one-hot, set busy_o, load CRC with CRC_INIT, latch crc_en_i and go to LOAD in the same edge; grant is visible the cycle after req_i is first seen.
REQ-022 In LOAD, if req_i[g] is high, SHALL drive utx_data_o=req_data_i[g], pulse utx_we_o and req_ack_o[g] for one cycle, update the CRC with that byte, latch req_last_i[g], clear the timeout counter and go to WAIT.
REQ-023 In LOAD, if req_i[g] is low, SHALL abort: send no byte, pulse err_o, and return to IDLE.
REQ-024 In WAIT, on utx_done_i: if not last, SHALL go to LOAD; if last and CRC latched, SHALL go to CRC_LOAD; if last and no CRC, SHALL go to IDLE.
REQ-025 In CRC_LOAD, SHALL drive utx_data_o=CRC register, pulse utx_we_o for one cycle (no req_ack_o) and go to CRC_WAIT; on utx_done_i, SHALL go to IDLE.
REQ-026 In WAIT and CRC_WAIT, if the counter reaches TIMEOUT-1 without utx_done_i, SHALL pulse err_o and go to IDLE.
REQ-027 SHALL ignore utx_done_i in IDLE, LOAD and CRC_LOAD.
REQ-028 On return to IDLE, SHALL clear grant_o and busy_o on the same edge; re-arbitration occurs no earlier than the following cycle.
REQ-029 SHALL compute the CRC byte-serially in one cycle: eight MSB-first shift/XOR steps with CRC_POLY.
REQ-030 SHALL keep req_i changes on non-granted requesters from affecting the current frame.
REQ-031 SHALL hold utx_data_o stable from the utx_we_o pulse until the next utx_we_o pulse.

Reset
REQ-032 While rst_i is low, SHALL be in IDLE with grant_o=0, req_ack_o=0, utx_data_o=0, utx_we_o=0, utx_en_o=0, busy_o=0, err_o=0, CRC=CRC_INIT, round-robin pointer=0 and timeout counter=0.
REQ-033 Reset asserted mid-frame SHALL drop utx_en_o immediately, with no err_o pulse and no CRC byte sent.

Structure
REQ-034 SHALL place FSM state encodings and CRC_POLY/CRC_INIT defaults in a shared package, uart_pkg.
REQ-035 SHALL implement the CRC step as sub-module crc8_step (combinational: crc_in, data_in -> crc_out).

Verification
REQ-036 Requester 0 sends frame {8'hDA, 8'h2D (last)} with crc_en_i=1 -> utx_data_o sequence 8'hDA, 8'h2D, 8'hFB; two req_ack_o[0] pulses; busy_o low after the third utx_done_i.
REQ-037 Requester 1 sends single byte 8'hDA (last) with crc_en_i=1 -> bytes 8'hDA, 8'h08; then same with crc_en_i=0 -> only 8'hDA sent.
REQ-038 req_i=4'b1011 held, one-byte frames each -> grant order 0,1,3,0,1.
REQ-039 No utx_done_i after a write, with TIMEOUT=16 -> err_o pulse 16 cycles after utx_we_o; state IDLE; grant_o=0.
REQ-040 rst_i pulled low during WAIT of a 3-byte frame -> all outputs 0 asynchronously; after release, req_i=4'b0100 -> grant_o=4'b0100 one cycle later.
